// File: rtl/irq_ctrl_pkg.sv
// Shared register map and ID-word layout for the irq_ctrl interrupt controller.
package irq_ctrl_pkg;

    localparam logic [2:0] REG_MASK = 3'd0;
    localparam logic [2:0] REG_MODE = 3'd1;
    localparam logic [2:0] REG_POL  = 3'd2;
    localparam logic [2:0] REG_PEND = 3'd3;
    localparam logic [2:0] REG_ID   = 3'd4;

    localparam int ID_VALID_BIT = 31;
    localparam int ID_W         = 5;

    function automatic logic [31:0] id_word(input logic valid, input logic [ID_W-1:0] id);
        id_word               = '0;
        id_word[ID_VALID_BIT] = valid;
        id_word[ID_W-1:0]     = id;
    endfunction

endpackage

// File: rtl/irq_sync.sv
// One interrupt channel front end: synchroniser, polarity correction and rise detect.
module irq_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic src_i,
    input  logic pol_i,
    output logic s_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], src_i};
            prev_q <= s_o;
        end
    end

    // prev tracks the polarity-corrected level, so a POL flip can look like an edge.
    assign s_o    = sync_q[SYNC_STAGES-1] ^ pol_i;
    assign rise_o = s_o & ~prev_q;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: per-channel mask/mode/polarity, pending latch, lowest-index claim ID, registered Irq.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int NUM_SRC     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic [NUM_SRC-1:0] Src,
    input  logic [2:0]         PrAddr,
    input  logic               PrWe,
    input  logic               PrRe,
    input  logic [31:0]        PrWd,
    output logic [31:0]        PrRd,
    output logic               Irq
);

    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic [NUM_SRC-1:0] mode_q, mode_d;
    logic [NUM_SRC-1:0] pol_q,  pol_d;
    logic [NUM_SRC-1:0] pend_q, pend_d;
    logic               irq_q,  irq_d;

    logic [NUM_SRC-1:0] s_w;
    logic [NUM_SRC-1:0] rise_w;
    logic [NUM_SRC-1:0] wd_w;
    logic [NUM_SRC-1:0] act_w;
    logic               id_valid_w;
    logic [ID_W-1:0]    id_w;
    logic               claim_w;
    logic               wr_mask_w, wr_mode_w, wr_pol_w, wr_pend_w;
    logic               unused_wd;

    generate
        for (genvar g = 0; g < NUM_SRC; g++) begin : g_chan
            irq_sync #(
                .SYNC_STAGES(SYNC_STAGES)
            ) u_sync (
                .clk_i  (Clock),
                .rst_i  (Reset),
                .src_i  (Src[g]),
                .pol_i  (pol_q[g]),
                .s_o    (s_w[g]),
                .rise_o (rise_w[g])
            );
        end
    endgenerate

    assign wd_w      = PrWd[NUM_SRC-1:0];
    assign unused_wd = ^PrWd;
    assign wr_mask_w = PrWe && (PrAddr == REG_MASK);
    assign wr_mode_w = PrWe && (PrAddr == REG_MODE);
    assign wr_pol_w  = PrWe && (PrAddr == REG_POL);
    assign wr_pend_w = PrWe && (PrAddr == REG_PEND);
    assign act_w     = pend_q & mask_q;

    // Lowest index wins: scan downwards so the last hit is the smallest.
    always_comb begin
        id_valid_w = 1'b0;
        id_w       = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (act_w[i]) begin
                id_valid_w = 1'b1;
                id_w       = ID_W'(i);
            end
        end
    end

    assign claim_w = PrRe && (PrAddr == REG_ID) && id_valid_w;

    always_comb begin
        mask_d = wr_mask_w ? wd_w : mask_q;
        mode_d = wr_mode_w ? wd_w : mode_q;
        pol_d  = wr_pol_w  ? wd_w : pol_q;
        irq_d  = |act_w;
        pend_d = pend_q;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!mode_q[i]) begin
                // Entering edge mode discards the level-derived pending state.
                if (wr_mode_w && wd_w[i]) begin
                    pend_d[i] = 1'b0;
                end else begin
                    pend_d[i] = s_w[i];
                end
            end else begin
                pend_d[i] = rise_w[i] |
                            (pend_q[i] & ~((wr_pend_w & wd_w[i]) |
                                           (claim_w & (id_w == ID_W'(i)))));
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            mask_q <= '0;
            mode_q <= '0;
            pol_q  <= '0;
            pend_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            mask_q <= mask_d;
            mode_q <= mode_d;
            pol_q  <= pol_d;
            pend_q <= pend_d;
            irq_q  <= irq_d;
        end
    end

    always_comb begin
        PrRd = '0;
        case (PrAddr)
            REG_MASK: PrRd = 32'(mask_q);
            REG_MODE: PrRd = 32'(mode_q);
            REG_POL:  PrRd = 32'(pol_q);
            REG_PEND: PrRd = 32'(pend_q);
            REG_ID:   PrRd = id_word(id_valid_w, id_w);
            default:  PrRd = '0;
        endcase
    end

    assign Irq = irq_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed self-checking bench for irq_ctrl (8-source and 32-source instances on a shared bus).
module tb_irq_ctrl;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [31:0] Src   = '0;
    logic [2:0]  PrAddr = '0;
    logic        PrWe  = 1'b0;
    logic        PrRe  = 1'b0;
    logic [31:0] PrWd  = '0;
    logic [31:0] PrRd8, PrRd32;
    logic        Irq8, Irq32;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 Clock = ~Clock;

    irq_ctrl #(.NUM_SRC(8), .SYNC_STAGES(2)) u_dut8 (
        .Clock(Clock), .Reset(Reset), .Src(Src[7:0]), .PrAddr(PrAddr),
        .PrWe(PrWe), .PrRe(PrRe), .PrWd(PrWd), .PrRd(PrRd8), .Irq(Irq8)
    );

    irq_ctrl #(.NUM_SRC(32), .SYNC_STAGES(2)) u_dut32 (
        .Clock(Clock), .Reset(Reset), .Src(Src), .PrAddr(PrAddr),
        .PrWe(PrWe), .PrRe(PrRe), .PrWd(PrWd), .PrRd(PrRd32), .Irq(Irq32)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input string tag, input logic [2:0] addr, input logic big,
                      input logic [31:0] exp);
        PrAddr = addr;
        #1;
        check(tag, big ? PrRd32 : PrRd8, exp);
    endtask

    task automatic wr(input logic [2:0] addr, input logic [31:0] data);
        PrAddr = addr;
        PrWd   = data;
        PrWe   = 1'b1;
        tick(1);
        PrWe   = 1'b0;
        PrWd   = '0;
    endtask

    initial begin
        tick(2);
        Reset = 1'b0;
        tick(1);

        // Reset state
        for (int a = 0; a < 8; a++) rd($sformatf("reset_rd%0d", a), 3'(a), 1'b0, 32'h0);
        check("reset_irq", {31'b0, Irq8}, 32'h0);

        // Masked level activity: PEND tracks, Irq stays low
        Src[0] = 1'b1;
        tick(3);
        rd("masked_pend_set", 3'd3, 1'b0, 32'h1);
        check("masked_irq_low", {31'b0, Irq8}, 32'h0);
        Src[0] = 1'b0;
        tick(3);
        rd("masked_pend_clr", 3'd3, 1'b0, 32'h0);

        // Level mode latency
        wr(3'd0, 32'h1);
        Src[0] = 1'b1;
        tick(3);
        check("lvl_irq_edge3", {31'b0, Irq8}, 32'h0);
        rd("lvl_pend_edge3", 3'd3, 1'b0, 32'h1);
        tick(1);
        check("lvl_irq_edge4", {31'b0, Irq8}, 32'h1);
        rd("lvl_id", 3'd4, 1'b0, 32'h8000_0000);
        Src[0] = 1'b0;
        tick(3);
        rd("lvl_pend_drop", 3'd3, 1'b0, 32'h0);
        check("lvl_irq_still", {31'b0, Irq8}, 32'h1);
        tick(1);
        check("lvl_irq_drop", {31'b0, Irq8}, 32'h0);

        // Edge mode, two sources, claims in priority order
        wr(3'd1, 32'hFF);
        wr(3'd0, 32'hFF);
        Src[3] = 1'b1;
        Src[5] = 1'b1;
        tick(1);
        Src[3] = 1'b0;
        Src[5] = 1'b0;
        tick(2);
        rd("edge_pend", 3'd3, 1'b0, 32'h28);
        rd("edge_id3", 3'd4, 1'b0, 32'h8000_0003);
        tick(1);
        check("edge_irq", {31'b0, Irq8}, 32'h1);
        PrAddr = 3'd4;
        PrRe   = 1'b1;
        #1;
        check("claim_preclear", PrRd8, 32'h8000_0003);
        tick(1);
        PrRe = 1'b0;
        rd("edge_id5", 3'd4, 1'b0, 32'h8000_0005);
        rd("edge_pend_after1", 3'd3, 1'b0, 32'h20);
        PrAddr = 3'd4;
        PrRe   = 1'b1;
        tick(1);
        PrRe = 1'b0;
        rd("edge_id_none", 3'd4, 1'b0, 32'h0);
        tick(1);
        check("edge_irq_drop", {31'b0, Irq8}, 32'h0);

        // Set and W1C on the same edge: set wins
        Src[2] = 1'b1;
        tick(2);
        wr(3'd3, 32'h04);
        rd("setwins_pend", 3'd3, 1'b0, 32'h04);
        wr(3'd3, 32'h04);
        rd("w1c_pend", 3'd3, 1'b0, 32'h0);
        Src[2] = 1'b0;

        // Polarity in level mode; W1C ignored for level bits
        wr(3'd1, 32'h00);
        wr(3'd2, 32'h02);
        tick(2);
        rd("pol_pend", 3'd3, 1'b0, 32'h02);
        wr(3'd3, 32'h02);
        rd("lvl_w1c_ignored", 3'd3, 1'b0, 32'h02);
        wr(3'd1, 32'h02);
        rd("lvl2edge_clear", 3'd3, 1'b0, 32'h0);
        tick(2);
        rd("lvl2edge_stays", 3'd3, 1'b0, 32'h0);

        // Upper bits of the narrow instance
        wr(3'd2, 32'h0);
        wr(3'd1, 32'hFFFF_FFFF);
        wr(3'd0, 32'hFFFF_FFFF);
        rd("mask8_upper_zero", 3'd0, 1'b0, 32'h0000_00FF);
        rd("mask32_full", 3'd0, 1'b1, 32'hFFFF_FFFF);
        tick(2);
        rd("pend32_quiet", 3'd3, 1'b1, 32'h0);

        // Highest channel on the 32-source instance
        Src[31] = 1'b1;
        tick(3);
        rd("id32_ch31", 3'd4, 1'b1, 32'h8000_001F);
        tick(1);
        check("irq32_high", {31'b0, Irq32}, 32'h1);
        check("irq8_quiet", {31'b0, Irq8}, 32'h0);

        // Asynchronous reset mid-pending
        Reset = 1'b1;
        #1;
        rd("rst_pend32", 3'd3, 1'b1, 32'h0);
        rd("rst_mask32", 3'd0, 1'b1, 32'h0);
        rd("rst_id32", 3'd4, 1'b1, 32'h0);
        check("rst_irq32", {31'b0, Irq32}, 32'h0);
        tick(1);
        Reset = 1'b0;
        tick(2);
        rd("repend_early", 3'd3, 1'b1, 32'h0);
        tick(1);
        rd("repend_edge3", 3'd3, 1'b1, 32'h8000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
